// File: rtl/posit_encode_round.sv
// posit_encode_round: rounds and packs a core result (sign, te, fraction, sticky)
// into an N-bit posit through a 3-stage valid/ready pipeline.
// Build option: define PPU_ENC_RNE_EN for round-to-nearest-even; without it the
// magnitude is truncated (round toward zero).
module posit_encode_round #(
  parameter int N              = 16,
  parameter int ES             = 1,
  parameter int FRAC_FULL_SIZE = 3 * N,
  parameter int TE_SIZE        = ES + $clog2(N) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sign,
  input  logic [TE_SIZE-1:0]        te,
  input  logic [FRAC_FULL_SIZE-1:0] frac,
  input  logic                      frac_lsb_cut_off,
  input  logic                      is_zero,
  input  logic                      is_nar,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              posit_out
);

  // Assembly width leaves room for the longest regime plus every exponent and
  // fraction bit, so sticky sees all dropped bits.
  localparam int AW = N + FRAC_FULL_SIZE + ES + 1;
  localparam int BW = ES + FRAC_FULL_SIZE;
  localparam int LW = $clog2(AW) + 1;
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
`ifdef PPU_ENC_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // ---------------- S1: decode ----------------
  logic signed [TE_SIZE-1:0] k_in;
  logic [LW-1:0]             len_in;
  logic                      sat_hi_in, sat_lo_in;

  // Regime run: k+1 ones plus terminator for k>=0, -k zeros plus terminator for k<0.
  always_comb begin
    k_in      = $signed(te) >>> ES;
    sat_hi_in = (int'(k_in) >= N - 2);
    sat_lo_in = (int'(k_in) <= -(N - 1));
    if (k_in[TE_SIZE-1]) len_in = LW'(1 - int'(k_in));
    else                 len_in = LW'(int'(k_in) + 2);
  end

  logic                      v1, s1_sign, s1_cut, s1_zero, s1_nar;
  logic                      s1_sat_hi, s1_sat_lo, s1_neg;
  logic [ES-1:0]             s1_e;
  logic [FRAC_FULL_SIZE-1:0] s1_frac;
  logic [LW-1:0]             s1_len;

  // Stage 1 register: captures the decoded beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0; s1_sign <= 1'b0; s1_cut <= 1'b0; s1_zero <= 1'b0; s1_nar <= 1'b0;
      s1_sat_hi <= 1'b0; s1_sat_lo <= 1'b0; s1_neg <= 1'b0;
      s1_e <= '0; s1_frac <= '0; s1_len <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      s1_sign   <= sign;
      s1_cut    <= frac_lsb_cut_off;
      s1_zero   <= is_zero;
      s1_nar    <= is_nar;
      s1_sat_hi <= sat_hi_in;
      s1_sat_lo <= sat_lo_in;
      s1_neg    <= k_in[TE_SIZE-1];
      s1_e      <= te[ES-1:0];
      s1_frac   <= frac;
      s1_len    <= len_in;
    end
  end

  // ---------------- S2: assemble ----------------
  logic [AW-1:0] regime_vec, body_vec, asm_vec;

  // Place regime at the top, then exponent and fraction shifted past it.
  always_comb begin
    body_vec = {s1_e, s1_frac, {(AW-BW){1'b0}}};
    if (s1_neg) regime_vec = {1'b1, {(AW-1){1'b0}}} >> (s1_len - 1'b1);
    else        regime_vec = ~({AW{1'b1}} >> (s1_len - 1'b1));
    asm_vec = regime_vec | (body_vec >> s1_len);
  end

  logic          v2, s2_sign, s2_guard, s2_sticky, s2_zero, s2_nar, s2_sat_hi, s2_sat_lo;
  logic [N-2:0]  s2_mag;

  // Stage 2 register: truncated magnitude plus guard/sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2 <= 1'b0; s2_sign <= 1'b0; s2_guard <= 1'b0; s2_sticky <= 1'b0;
      s2_zero <= 1'b0; s2_nar <= 1'b0; s2_sat_hi <= 1'b0; s2_sat_lo <= 1'b0;
      s2_mag <= '0;
    end else if (adv) begin
      v2        <= v1;
      s2_sign   <= s1_sign;
      s2_mag    <= asm_vec[AW-1 -: N-1];
      s2_guard  <= asm_vec[AW-N];
      s2_sticky <= (|asm_vec[AW-N-1:0]) | s1_cut;
      s2_zero   <= s1_zero;
      s2_nar    <= s1_nar;
      s2_sat_hi <= s1_sat_hi;
      s2_sat_lo <= s1_sat_lo;
    end
  end

  // ---------------- S3: round and pack ----------------
  logic         round_up;
  logic [N-1:0] sum, mag, res;

  // Round, clamp into [minpos, maxpos], apply sign, then override specials.
  always_comb begin
    round_up = RNE_EN & s2_guard & (s2_sticky | s2_mag[0]);
    sum      = {1'b0, s2_mag} + {{(N-1){1'b0}}, round_up};
    mag      = sum[N-1] ? MAXPOS : sum;
    if (s2_sat_hi)                      mag = MAXPOS;
    else if (s2_sat_lo || mag == '0)    mag = MINPOS;
    res = s2_sign ? (~mag + 1'b1) : mag;
    if (s2_nar)       res = NAR;
    else if (s2_zero) res = '0;
  end

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      posit_out <= '0;
    end else if (adv) begin
      out_valid <= v2;
      posit_out <= res;
    end
  end

endmodule

// File: tb/tb_posit_encode_round.sv
// Testbench for posit_encode_round (N=16, ES=1, FRAC_FULL_SIZE=48): directed
// vectors, backpressure, mid-flight reset and randomized traffic checked against
// a bit-string reference model.
module tb_posit_encode_round;
  localparam int N  = 16;
  localparam int ES = 1;
  localparam int FS = 48;
`ifdef PPU_ENC_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic          sign = 1'b0;
  logic [5:0]    te = '0;
  logic [FS-1:0] frac = '0;
  logic          frac_lsb_cut_off = 1'b0, is_zero = 1'b0, is_nar = 1'b0;
  logic          out_valid, out_ready = 1'b1;
  logic [N-1:0]  posit_out;

  always #5 clk = ~clk;

  posit_encode_round #(.N(N), .ES(ES), .FRAC_FULL_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sign(sign), .te(te),
    .frac(frac), .frac_lsb_cut_off(frac_lsb_cut_off), .is_zero(is_zero), .is_nar(is_nar),
    .out_valid(out_valid), .out_ready(out_ready), .posit_out(posit_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: spell out regime/exponent/fraction as a bit string, cut, round.
  function automatic logic [15:0] ref_posit(input logic s, input logic [5:0] t,
                                             input logic [FS-1:0] f, input logic c,
                                             input logic z, input logic nr);
    int ti, k, mag;
    bit q[$];
    bit g, st;
    if (nr) return 16'h8000;
    if (z)  return 16'h0000;
    ti = int'($signed(t));
    k  = ti >>> 1;
    if (k >= 14)       mag = 32'h7FFF;
    else if (k <= -15) mag = 1;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(t[0]);
      for (int i = FS - 1; i >= 0; i--) q.push_back(f[i]);
      mag = 0;
      for (int i = 0; i < 15; i++) mag = mag * 2 + int'(q[i]);
      g  = q[15];
      st = c;
      for (int i = 16; i < q.size(); i++) st |= q[i];
      if (RNE && g && (st || (mag % 2 == 1))) mag++;
      if (mag > 32767) mag = 32767;
      if (mag == 0) mag = 1;
    end
    return s ? 16'(-mag) : 16'(mag);
  endfunction

  typedef struct {
    logic [15:0] exp;
    int          cyc;
  } ent_t;

  ent_t        sb[$];
  ent_t        e_pop, e_new;
  int          cyc = 0;
  logic        use_dir = 1'b0;
  logic        lat_chk = 1'b0;
  logic [15:0] dir_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_out", {16'h0, posit_out}, 32'hFFFF_FFFF);
        end else begin
          e_pop = sb.pop_front();
          check_val("posit", {16'h0, posit_out}, {16'h0, e_pop.exp});
          if (lat_chk) check_val("latency", cyc - e_pop.cyc, 3);
        end
      end
      if (in_valid && in_ready) begin
        e_new.exp = use_dir ? dir_exp
                            : ref_posit(sign, te, frac, frac_lsb_cut_off, is_zero, is_nar);
        e_new.cyc = cyc;
        sb.push_back(e_new);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [5:0] t, input logic [FS-1:0] f,
                      input logic c, input logic z, input logic nr);
    int  n;
    logic acc;
    sign = s; te = t; frac = f; frac_lsb_cut_off = c; is_zero = z; is_nar = nr;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready && rst;
      step();
      n++;
    end
    if (!acc) check_val("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand;
    send(1'($urandom), 6'($urandom_range(0, 63)), {16'($urandom), $urandom},
         1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check_val("drain", sb.size(), 0);
  endtask

  typedef struct {
    logic          s;
    logic [5:0]    t;
    logic [FS-1:0] f;
    logic          c, z, nr;
    logic [15:0]   exp;
  } vec_t;

  vec_t dv[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dv[0] = '{1'b0, 6'd0,  48'h0000_0000_0000, 1'b0, 1'b0, 1'b0, 16'h4000};
    dv[1] = '{1'b0, 6'd0,  48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 16'h4800};
    dv[2] = '{1'b1, 6'd0,  48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 16'hB800};
    dv[3] = '{1'b0, 6'd0,  48'h0008_0000_0000, 1'b0, 1'b0, 1'b0, 16'h4000};
    dv[4] = '{1'b0, 6'd0,  48'h0008_0000_0000, 1'b1, 1'b0, 1'b0, RNE ? 16'h4001 : 16'h4000};
    dv[5] = '{1'b0, 6'd31, 48'h1234_5678_9ABC, 1'b0, 1'b0, 1'b0, 16'h7FFF};
    dv[6] = '{1'b0, 6'h20, 48'h1234_5678_9ABC, 1'b0, 1'b0, 1'b0, 16'h0001};
    dv[7] = '{1'b1, 6'h20, 48'h0000_0000_0000, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    dv[8] = '{1'b1, 6'd5,  48'hFFFF_0000_1111, 1'b1, 1'b1, 1'b1, 16'h8000};
    dv[9] = '{1'b1, 6'd7,  48'hABCD_0000_1111, 1'b0, 1'b1, 1'b0, 16'h0000};

    // Reset held with toggling inputs: nothing may come out.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      te = 6'($urandom); frac = {16'($urandom), $urandom}; out_ready = 1'($urandom);
      @(negedge clk);
      check_val("rst_out_valid", {31'h0, out_valid}, 0);
      check_val("rst_posit", {16'h0, posit_out}, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", {31'h0, in_ready}, 1);
    step();

    // Directed vectors back to back at full throughput.
    use_dir = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dir_exp = dv[i].exp;
      send(dv[i].s, dv[i].t, dv[i].f, dv[i].c, dv[i].z, dv[i].nr);
    end
    drain();
    use_dir = 1'b0;

    // Backpressure: 5 beats then a 4-cycle stall.
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) send_rand();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("bp_in_ready", {31'h0, in_ready}, 0);
      check_val("bp_out_valid", {31'h0, out_valid}, 1);
      check_val("bp_hold", {16'h0, posit_out},
                (sb.size() > 0) ? {16'h0, sb[0].exp} : 32'hDEAD_BEEF);
      step();
    end
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("midrst_out_valid", {31'h0, out_valid}, 0);
      check_val("midrst_posit", {16'h0, posit_out}, 0);
      step();
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("post_rst_idle", {31'h0, out_valid}, 0);
      step();
    end
    use_dir = 1'b1;
    lat_chk = 1'b1;
    dir_exp = 16'h4800;
    send(1'b0, 6'd0, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0);
    drain();
    use_dir = 1'b0;
    lat_chk = 1'b0;

    // Randomized traffic with random valid/ready.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sign = 1'($urandom);
      te = 6'($urandom_range(0, 63));
      frac = {16'($urandom), $urandom};
      frac_lsb_cut_off = 1'($urandom);
      is_zero = ($urandom_range(0, 15) == 0);
      is_nar  = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
